// File: rtl/joypad_responder_if.sv
// Pin bundle between a console-side driver (master) and the joypad responder (slave).
interface joypad_responder_if;
    logic [7:0] buttons_in;
    logic       jp_latch_in;
    logic       jp_clk_in;
    logic       jp_data_out;
    logic       poll_out;
    logic [3:0] bit_cnt_out;

    modport slave  (input  buttons_in, jp_latch_in, jp_clk_in,
                    output jp_data_out, poll_out, bit_cnt_out);
    modport master (output buttons_in, jp_latch_in, jp_clk_in,
                    input  jp_data_out, poll_out, bit_cnt_out);
endinterface

// File: rtl/joypad_responder.sv
// Console joypad shift-register responder with pin synchronizers.
// Optional button debounce is enabled by defining JP_RESP_DEBOUNCE_EN.
module joypad_responder #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    joypad_responder_if.slave jp
);
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit layout of each synchronizer stage: [9:2] buttons, [1] latch, [0] shift clock.
    logic [SYNC_STAGES-1:0][9:0] sync_q;
    logic [9:0] sync_last_s;
    logic [7:0] btn_s;
    logic       latch_prev_q, clk_prev_q, latch_fall_q, clk_rise_q;

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] cnt_q, cnt_d;
    logic       start_q, start_d;
    logic       jp_data_q, jp_data_d;
    logic       poll_q, poll_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;

    // Synchronizer chain for all asynchronous pins
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {jp.buttons_in, jp.jp_latch_in, jp.jp_clk_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_last_s = sync_q[SYNC_STAGES-1];

    // Edge detection against a delayed copy; results are registered once more
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            latch_prev_q <= 1'b0;
            clk_prev_q   <= 1'b0;
            latch_fall_q <= 1'b0;
            clk_rise_q   <= 1'b0;
        end else begin
            latch_prev_q <= sync_last_s[1];
            clk_prev_q   <= sync_last_s[0];
            latch_fall_q <= latch_prev_q & ~sync_last_s[1];
            clk_rise_q   <= sync_last_s[0] & ~clk_prev_q;
        end
    end

`ifdef JP_RESP_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0] db_cnt_q [8];
    logic [7:0]      db_acc_q;

    // A button flips only after a full run of consecutive samples that disagree with it
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            db_acc_q <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (sync_last_s[i+2] == db_acc_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_acc_q[i] <= sync_last_s[i+2];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign btn_s = db_acc_q;
`else
    assign btn_s = sync_last_s[9:2];
`endif

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_LOAD;
            shreg_q <= 8'd0;
            cnt_q   <= 4'd0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    // Next-state logic; a high latch overrides everything, including a same-cycle clock edge
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        if (latch_prev_q) begin
            state_d = ST_LOAD;
            shreg_d = btn_s;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (latch_fall_q) begin
                        state_d = ST_SHIFT;
                        start_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise_q) begin
                        shreg_d = {1'b0, shreg_q[7:1]};
                        cnt_d   = cnt_q + 4'd1;
                        state_d = (cnt_q == 4'd7) ? ST_DONE : ST_SHIFT;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_LOAD;
                    shreg_d = 8'd0;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Output decode; an empty shift register after reset naturally idles the line high
    always_comb begin
        if (state_q == ST_DONE) begin
            jp_data_d = 1'b0;
        end else begin
            jp_data_d = ~shreg_q[0];
        end
        poll_d    = start_q;
        bit_cnt_d = cnt_q;
    end

    // Output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            jp_data_q <= 1'b1;
            poll_q    <= 1'b0;
            bit_cnt_q <= 4'd0;
        end else begin
            jp_data_q <= jp_data_d;
            poll_q    <= poll_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign jp.jp_data_out = jp_data_q;
    assign jp.poll_out    = poll_q;
    assign jp.bit_cnt_out = bit_cnt_q;
endmodule

// File: tb/tb_joypad_responder.sv
// Self-checking bench for joypad_responder against a frame-level reference model.
module tb_joypad_responder;
    localparam int SYNC   = 2;
    localparam int DBC    = 16;
    localparam int SETTLE = SYNC + 4;
`ifdef JP_RESP_DEBOUNCE_EN
    localparam int BTN_SETTLE = SETTLE + DBC + 2;
`else
    localparam int BTN_SETTLE = SETTLE;
`endif

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   poll_seen = 0;

    joypad_responder_if jp_bus();

    joypad_responder #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DBC)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .jp     (jp_bus)
    );

    always #5 clk_in = ~clk_in;

    // Counts cycles with poll high, so a stretched pulse shows up as an extra count
    always @(negedge clk_in) begin
        if (jp_bus.poll_out === 1'b1) poll_seen++;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

    // Reference model: after k shifts of a captured byte the line carries ~bit k, then 0.
    function automatic logic exp_data(input logic [7:0] cap, input int k);
        if (k >= 8) return 1'b0;
        return ~cap[k];
    endfunction

    function automatic logic [3:0] exp_cnt(input int k);
        return (k >= 8) ? 4'd8 : 4'(k);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic latch_frame(input logic [7:0] b, input int hold);
        jp_bus.buttons_in = b;
        step(BTN_SETTLE);
        jp_bus.jp_latch_in = 1'b1;
        step(hold);
        jp_bus.jp_latch_in = 1'b0;
        step(SETTLE);
    endtask

    task automatic clk_pulse(input int hi, input int lo);
        jp_bus.jp_clk_in = 1'b1;
        step(hi);
        jp_bus.jp_clk_in = 1'b0;
        step(lo);
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        jp_bus.buttons_in  = 8'h00;
        jp_bus.jp_latch_in = 1'b0;
        jp_bus.jp_clk_in   = 1'b0;
        step(3);
        checks++; if (jp_bus.jp_data_out !== 1'b1) begin errors++; $display("FAIL reset_data_in: got %b expected 1", jp_bus.jp_data_out); end
        checks++; if (jp_bus.bit_cnt_out !== 4'd0) begin errors++; $display("FAIL reset_cnt_in: got %0d expected 0", jp_bus.bit_cnt_out); end
        rst_in = 1'b0;
        step(SETTLE);
        checks++; if (jp_bus.jp_data_out !== 1'b1) begin errors++; $display("FAIL reset_data: got %b expected 1", jp_bus.jp_data_out); end
        checks++; if (jp_bus.bit_cnt_out !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", jp_bus.bit_cnt_out); end
        checks++; if (jp_bus.poll_out !== 1'b0) begin errors++; $display("FAIL reset_poll: got %b expected 0", jp_bus.poll_out); end
    endtask

    task automatic test_fixed_frame;
        int p0;
        p0 = poll_seen;
        latch_frame(8'h09, 12);
        checks++; if (jp_bus.jp_data_out !== 1'b0) begin errors++; $display("FAIL fixed_bit0: got %b expected 0", jp_bus.jp_data_out); end
        for (int k = 1; k <= 10; k++) begin
            clk_pulse(6, 6);
            checks++;
            if (jp_bus.jp_data_out !== exp_data(8'h09, k) || jp_bus.bit_cnt_out !== exp_cnt(k)) begin
                errors++;
                $display("FAIL fixed_shift%0d: got data %b cnt %0d expected data %b cnt %0d",
                         k, jp_bus.jp_data_out, jp_bus.bit_cnt_out, exp_data(8'h09, k), exp_cnt(k));
            end
        end
        checks++; if (poll_seen - p0 != 1) begin errors++; $display("FAIL fixed_poll: got %0d pulse cycles expected 1", poll_seen - p0); end
    endtask

    task automatic test_random_frames;
        logic [7:0] b;
        int n, p0;
        repeat (6) begin
            b  = 8'($urandom);
            p0 = poll_seen;
            latch_frame(b, $urandom_range(2, 20));
            jp_bus.buttons_in = 8'($urandom);
            checks++; if (poll_seen - p0 != 1) begin errors++; $display("FAIL rand_poll: got %0d expected 1", poll_seen - p0); end
            checks++; if (jp_bus.jp_data_out !== exp_data(b, 0)) begin errors++; $display("FAIL rand_bit0 b=%h: got %b expected %b", b, jp_bus.jp_data_out, exp_data(b, 0)); end
            n = $urandom_range(1, 10);
            for (int k = 1; k <= n; k++) begin
                clk_pulse($urandom_range(2, 8), $urandom_range(SETTLE, SETTLE + 3));
                if (k % 3 == 0) jp_bus.buttons_in = 8'($urandom);
                checks++;
                if (jp_bus.jp_data_out !== exp_data(b, k) || jp_bus.bit_cnt_out !== exp_cnt(k)) begin
                    errors++;
                    $display("FAIL rand_shift%0d b=%h: got data %b cnt %0d expected data %b cnt %0d",
                             k, b, jp_bus.jp_data_out, jp_bus.bit_cnt_out, exp_data(b, k), exp_cnt(k));
                end
            end
        end
    endtask

    task automatic test_button_change;
        latch_frame(8'hFF, 8);
        for (int k = 1; k <= 3; k++) clk_pulse(6, 6);
        jp_bus.buttons_in = 8'h00;
        for (int k = 4; k <= 8; k++) begin
            clk_pulse(6, 6);
            checks++; if (jp_bus.jp_data_out !== 1'b0) begin errors++; $display("FAIL change_shift%0d: got %b expected 0", k, jp_bus.jp_data_out); end
        end
        checks++; if (jp_bus.bit_cnt_out !== 4'd8) begin errors++; $display("FAIL change_cnt: got %0d expected 8", jp_bus.bit_cnt_out); end
        latch_frame(8'h00, 8);
        checks++; if (jp_bus.jp_data_out !== 1'b1) begin errors++; $display("FAIL change_reload: got %b expected 1", jp_bus.jp_data_out); end
    endtask

    task automatic test_latch_wins;
        logic [7:0] b;
        b = 8'($urandom);
        latch_frame(b, 8);
        for (int k = 1; k <= 4; k++) clk_pulse(6, 6);
        jp_bus.jp_latch_in = 1'b1;
        jp_bus.jp_clk_in   = 1'b1;
        step(SETTLE);
        checks++; if (jp_bus.bit_cnt_out !== 4'd0) begin errors++; $display("FAIL latchwin_cnt: got %0d expected 0", jp_bus.bit_cnt_out); end
        checks++; if (jp_bus.jp_data_out !== ~b[0]) begin errors++; $display("FAIL latchwin_data: got %b expected %b", jp_bus.jp_data_out, ~b[0]); end
        jp_bus.jp_clk_in   = 1'b0;
        step(2);
        jp_bus.jp_latch_in = 1'b0;
        step(SETTLE);
        checks++; if (jp_bus.jp_data_out !== ~b[0] || jp_bus.bit_cnt_out !== 4'd0) begin errors++; $display("FAIL latchwin_after: got data %b cnt %0d expected data %b cnt 0", jp_bus.jp_data_out, jp_bus.bit_cnt_out, ~b[0]); end
        clk_pulse(6, 6);
        checks++; if (jp_bus.jp_data_out !== ~b[1] || jp_bus.bit_cnt_out !== 4'd1) begin errors++; $display("FAIL latchwin_shift1: got data %b cnt %0d expected data %b cnt 1", jp_bus.jp_data_out, jp_bus.bit_cnt_out, ~b[1]); end
    endtask

    task automatic test_reset_midframe;
        int p0;
        latch_frame(8'h5B, 8);
        for (int k = 1; k <= 5; k++) clk_pulse(6, 6);
        checks++; if (jp_bus.bit_cnt_out !== 4'd5) begin errors++; $display("FAIL midrst_pre: got %0d expected 5", jp_bus.bit_cnt_out); end
        jp_bus.buttons_in = 8'hFF;
        rst_in = 1'b1;
        step(2);
        rst_in = 1'b0;
        step(SETTLE);
        checks++; if (jp_bus.jp_data_out !== 1'b1 || jp_bus.bit_cnt_out !== 4'd0) begin errors++; $display("FAIL midrst_post: got data %b cnt %0d expected data 1 cnt 0", jp_bus.jp_data_out, jp_bus.bit_cnt_out); end
        p0 = poll_seen;
        for (int k = 1; k <= 3; k++) begin
            clk_pulse(6, 6);
            checks++; if (jp_bus.jp_data_out !== 1'b1 || jp_bus.bit_cnt_out !== 4'd0) begin errors++; $display("FAIL midrst_clk%0d: got data %b cnt %0d expected data 1 cnt 0", k, jp_bus.jp_data_out, jp_bus.bit_cnt_out); end
        end
        checks++; if (poll_seen != p0) begin errors++; $display("FAIL midrst_poll: got %0d expected 0", poll_seen - p0); end
    endtask

    task automatic test_latency;
        latch_frame(8'h02, 8);
        checks++; if (jp_bus.jp_data_out !== 1'b1) begin errors++; $display("FAIL lat_pre: got %b expected 1", jp_bus.jp_data_out); end
        jp_bus.jp_clk_in = 1'b1;
        for (int i = 1; i <= SYNC + 3; i++) begin
            step(1);
            if (i == SYNC + 2) begin
                checks++; if (jp_bus.jp_data_out !== 1'b1) begin errors++; $display("FAIL lat_early: got %b expected 1 at edge %0d", jp_bus.jp_data_out, i); end
            end
            if (i == SYNC + 3) begin
                checks++; if (jp_bus.jp_data_out !== 1'b0) begin errors++; $display("FAIL lat_exact: got %b expected 0 at edge %0d", jp_bus.jp_data_out, i); end
            end
        end
        jp_bus.jp_clk_in = 1'b0;
        step(SETTLE);
    endtask

`ifdef JP_RESP_DEBOUNCE_EN
    task automatic test_debounce;
        jp_bus.buttons_in = 8'h00;
        rst_in = 1'b1;
        step(2);
        rst_in = 1'b0;
        jp_bus.jp_latch_in = 1'b1;
        step(SETTLE);
        jp_bus.buttons_in = 8'h01;
        step(10);
        jp_bus.buttons_in = 8'h00;
        step(SETTLE + DBC);
        checks++; if (jp_bus.jp_data_out !== 1'b1) begin errors++; $display("FAIL db_glitch: got %b expected 1", jp_bus.jp_data_out); end
        jp_bus.buttons_in = 8'h01;
        step(20 + SETTLE);
        checks++; if (jp_bus.jp_data_out !== 1'b0) begin errors++; $display("FAIL db_held: got %b expected 0", jp_bus.jp_data_out); end
        jp_bus.jp_latch_in = 1'b0;
        step(SETTLE);
    endtask
`endif

    initial begin
        test_reset();
        test_fixed_frame();
        test_random_frames();
        test_button_change();
        test_latch_wins();
        test_reset_midframe();
        test_latency();
`ifdef JP_RESP_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
